// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between the frame RAM arbiter, its two requesters and the RAM itself.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface frame_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8
);
  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic [DATA_WIDTH-1:0] vga_rdata;
  logic                  vga_rvalid;
  logic                  vga_underrun;
  logic                  alg_req;
  logic                  alg_we;
  logic [ADDR_WIDTH-1:0] alg_addr;
  logic [DATA_WIDTH-1:0] alg_wdata;
  logic                  alg_gnt;
  logic [DATA_WIDTH-1:0] alg_rdata;
  logic                  alg_rvalid;
  logic                  alg_lock;
  logic                  lock_ack;
  logic                  addr_err;
  logic [15:0]           underrun_count;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr, alg_req, alg_we, alg_addr, alg_wdata, alg_lock, mem_q,
    output vga_rdata, vga_rvalid, vga_underrun, alg_gnt, alg_rdata, alg_rvalid,
           lock_ack, addr_err, underrun_count, mem_addr, mem_data, mem_wren
  );

  modport master (
    output vga_req, vga_addr, alg_req, alg_we, alg_addr, alg_wdata, alg_lock, mem_q,
    input  vga_rdata, vga_rvalid, vga_underrun, alg_gnt, alg_rdata, alg_rvalid,
           lock_ack, addr_err, underrun_count, mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Single-port frame RAM arbiter: VGA scan-out vs algorithm port, with starvation
// guard, tagged read-return pipeline and an exclusive lock mode for zoom engines.
module frame_mem_arbiter #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 76800,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  frame_mem_arbiter_if.slave bus
);
  localparam int TAG_N = READ_LATENCY + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {SHARED, DRAIN, LOCKED} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [TAG_N-1:0] tag_vld_p, tag_vga_p, tag_oor_p;

  logic                  forced, vga_accept, vga_drop, alg_accept;
  logic                  vga_oor, alg_oor, acc_oor, vga_in_flight, enter_locked;
  logic                  ret_vga, ret_alg;
  logic [DATA_WIDTH-1:0] ret_data;

  function automatic logic [DATA_WIDTH-1:0] blank_oor(input logic oor,
                                                      input logic [DATA_WIDTH-1:0] q);
    return oor ? '0 : q;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A VGA request that collides with a forced alg grant is lost; requests during
  // DRAIN/LOCKED are intentionally ignored and never counted as underruns.
  assign forced        = (state == SHARED) && (starve_cnt == LIMIT_C);
  assign bus.alg_gnt   = ~reset & ((state != SHARED) | forced | ~bus.vga_req);
  assign vga_accept    = (state == SHARED) & bus.vga_req & ~forced;
  assign vga_drop      = (state == SHARED) & bus.vga_req & forced;
  assign alg_accept    = bus.alg_req & bus.alg_gnt;
  assign vga_oor       = bus.vga_addr >= DEPTH_A;
  assign alg_oor       = bus.alg_addr >= DEPTH_A;
  assign acc_oor       = alg_accept ? alg_oor : vga_oor;
  assign vga_in_flight = |(tag_vld_p & tag_vga_p);
  assign enter_locked  = bus.alg_lock &
                         ((state == LOCKED) | ((state == DRAIN) & ~vga_in_flight));
  assign ret_vga       = tag_vld_p[TAG_N-1] & tag_vga_p[TAG_N-1];
  assign ret_alg       = tag_vld_p[TAG_N-1] & ~tag_vga_p[TAG_N-1];
  assign ret_data      = blank_oor(tag_oor_p[TAG_N-1], bus.mem_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= SHARED;
      starve_cnt         <= '0;
      tag_vld_p          <= '0;
      tag_vga_p          <= '0;
      tag_oor_p          <= '0;
      bus.lock_ack       <= 1'b0;
      bus.vga_underrun   <= 1'b0;
      bus.underrun_count <= '0;
      bus.mem_addr       <= '0;
      bus.mem_data       <= '0;
      bus.mem_wren       <= 1'b0;
      bus.addr_err       <= 1'b0;
      bus.vga_rvalid     <= 1'b0;
      bus.vga_rdata      <= '0;
      bus.alg_rvalid     <= 1'b0;
      bus.alg_rdata      <= '0;
    end else begin
      case (state)
        SHARED:  if (bus.alg_lock) state <= DRAIN;
        DRAIN:   if (!bus.alg_lock) state <= SHARED;
                 else if (!vga_in_flight) state <= LOCKED;
        LOCKED:  if (!bus.alg_lock) state <= SHARED;
        default: state <= SHARED;
      endcase
      bus.lock_ack <= enter_locked;

      if (alg_accept || !bus.alg_req) starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + CNT_W'(1);

      bus.vga_underrun <= vga_drop;
      if (vga_drop) bus.underrun_count <= sat_inc16(bus.underrun_count);

      // issue stage: RAM address/data/enable registered on the accept edge
      if (vga_accept) begin
        bus.mem_addr <= bus.vga_addr;
      end else if (alg_accept) begin
        bus.mem_addr <= bus.alg_addr;
        bus.mem_data <= bus.alg_wdata;
      end
      bus.mem_wren <= alg_accept & bus.alg_we & ~alg_oor;
      bus.addr_err <= (vga_accept | alg_accept) & acc_oor;

      tag_vld_p <= {tag_vld_p[TAG_N-2:0], vga_accept | (alg_accept & ~bus.alg_we)};
      tag_vga_p <= {tag_vga_p[TAG_N-2:0], vga_accept};
      tag_oor_p <= {tag_oor_p[TAG_N-2:0], acc_oor};

      // return stage: steer RAM output to the requester that issued the read
      bus.vga_rvalid <= ret_vga;
      bus.alg_rvalid <= ret_alg;
      if (ret_vga) bus.vga_rdata <= ret_data;
      else if (enter_locked) bus.vga_rdata <= '0;
      if (ret_alg) bus.alg_rdata <= ret_data;
    end
  end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: directed scenarios plus a randomized run scored
// against a cycle-indexed event table built from the arbitration rules.
module tb_frame_mem_arbiter;
  localparam int AW    = 18;
  localparam int DW    = 8;
  localparam int DEPTH = 76800;
  localparam int IW    = 17;
  localparam int N     = 800;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  frame_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  frame_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .READ_LATENCY(2), .STARVE_LIMIT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // RAM with two-cycle read latency; out-of-range reads return junk on purpose
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] q1;
  bit            loaded = 1'b0;

  function automatic logic [DW-1:0] pattern(input int a);
    return DW'(a + 16 + (a >> 8));
  endfunction

  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pattern(i);
      loaded <= 1'b1;
    end else if (bus.mem_wren) begin
      ram[IW'(bus.mem_addr)] <= bus.mem_data;
    end
    q1 <= (bus.mem_addr < AW'(DEPTH)) ? ram[IW'(bus.mem_addr)] : 8'hEE;
    bus.mem_q <= q1;
  end

  logic [DW-1:0] gold [DEPTH];
  logic          e_vv [N+8];
  logic          e_av [N+8];
  logic          e_wren [N+8];
  logic          e_err [N+8];
  logic          e_und [N+8];
  logic [DW-1:0] e_vd [N+8];
  logic [DW-1:0] e_ad [N+8];

  task automatic drive(input logic vr, input int va, input logic ar, input logic aw,
                       input int aa, input logic [7:0] ad, input logic lk);
    bus.vga_req   = vr;
    bus.vga_addr  = AW'(va);
    bus.alg_req   = ar;
    bus.alg_we    = aw;
    bus.alg_addr  = AW'(aa);
    bus.alg_wdata = ad;
    bus.alg_lock  = lk;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    n_checks++;
    if ({bus.vga_rvalid, bus.vga_underrun, bus.alg_gnt, bus.alg_rvalid, bus.lock_ack,
         bus.addr_err, bus.mem_wren} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000000", {bus.vga_rvalid, bus.vga_underrun,
               bus.alg_gnt, bus.alg_rvalid, bus.lock_ack, bus.addr_err, bus.mem_wren});
    end
    n_checks++;
    if ({bus.vga_rdata, bus.alg_rdata, bus.mem_data} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h want 0", bus.vga_rdata, bus.alg_rdata, bus.mem_data);
    end
    n_checks++;
    if (bus.mem_addr !== 18'd0 || bus.underrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_addr_cnt got %h %h want 0", bus.mem_addr, bus.underrun_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_vga_reads();
    logic          ev;
    logic [DW-1:0] ed;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      ev = (k >= 4 && k <= 6);
      ed = 8'h10 + 8'(k - 4);
      n_checks++;
      if (bus.vga_rvalid !== ev) begin
        n_fail++;
        $display("FAIL vga_reads_rvalid k=%0d got %b want %b", k, bus.vga_rvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if (bus.vga_rdata !== ed) begin
          n_fail++;
          $display("FAIL vga_reads_data k=%0d got %h want %h", k, bus.vga_rdata, ed);
        end
      end
      n_checks++;
      if (bus.alg_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL vga_reads_alg_rvalid k=%0d got %b want 0", k, bus.alg_rvalid);
      end
      if (k < 3) drive(1, k, 0, 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (k < 3) begin
        n_checks++;
        if (bus.alg_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL vga_reads_gnt k=%0d got %b want 0", k, bus.alg_gnt);
        end
      end
    end
  endtask

  task automatic test_alg_write_read();
    logic ev;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        n_checks++;
        if ({bus.mem_wren, bus.mem_addr, bus.mem_data} !== {1'b1, 18'd100, 8'hA5}) begin
          n_fail++;
          $display("FAIL alg_write_issue got %b %0d %h want 1 100 a5",
                   bus.mem_wren, bus.mem_addr, bus.mem_data);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (bus.mem_wren !== 1'b0) begin
          n_fail++;
          $display("FAIL alg_read_wren got %b want 0", bus.mem_wren);
        end
      end
      if (k >= 2) begin
        ev = (k == 5);
        n_checks++;
        if (bus.alg_rvalid !== ev) begin
          n_fail++;
          $display("FAIL alg_read_rvalid k=%0d got %b want %b", k, bus.alg_rvalid, ev);
        end
        if (ev) begin
          n_checks++;
          if (bus.alg_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL alg_read_data got %h want a5", bus.alg_rdata);
          end
        end
      end
      if (k == 0) drive(0, 0, 1, 1, 100, 8'hA5, 0);
      else if (k == 1) drive(0, 0, 1, 0, 100, 8'h00, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (k < 2) begin
        n_checks++;
        if (bus.alg_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL alg_gnt_idle k=%0d got %b want 1", k, bus.alg_gnt);
        end
      end
    end
    gold[100] = 8'hA5;
  endtask

  task automatic test_starvation();
    int   j;
    int   pulses = 0;
    logic ev;
    for (int k = 0; k < 26; k++) begin
      @(negedge clock);
      j  = k - 4;
      ev = (j >= 0 && j < 20 && j != 15);
      n_checks++;
      if (bus.vga_rvalid !== ev) begin
        n_fail++;
        $display("FAIL starve_vga_rvalid k=%0d got %b want %b", k, bus.vga_rvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if (bus.vga_rdata !== gold[200 + j]) begin
          n_fail++;
          $display("FAIL starve_vga_data k=%0d got %h want %h", k, bus.vga_rdata, gold[200 + j]);
        end
      end
      n_checks++;
      if (bus.alg_rvalid !== (k == 19)) begin
        n_fail++;
        $display("FAIL starve_alg_rvalid k=%0d got %b want %b", k, bus.alg_rvalid, k == 19);
      end
      if (k == 19) begin
        n_checks++;
        if (bus.alg_rdata !== gold[7]) begin
          n_fail++;
          $display("FAIL starve_alg_data got %h want %h", bus.alg_rdata, gold[7]);
        end
      end
      if (k == 15) begin
        n_checks++;
        if (bus.underrun_count !== 16'd0) begin
          n_fail++;
          $display("FAIL starve_count_before got %0d want 0", bus.underrun_count);
        end
      end
      if (bus.vga_underrun === 1'b1) pulses++;
      drive(k < 20, 200 + k, k <= 15, 0, 7, 8'h00, 0);
      #1;
      if (k < 20) begin
        n_checks++;
        if (bus.alg_gnt !== (k == 15)) begin
          n_fail++;
          $display("FAIL starve_gnt k=%0d got %b want %b", k, bus.alg_gnt, k == 15);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL starve_underrun_pulses got %0d want 1", pulses);
    end
    n_checks++;
    if (bus.underrun_count !== 16'd1) begin
      n_fail++;
      $display("FAIL starve_count got %0d want 1", bus.underrun_count);
    end
  endtask

  task automatic test_lock();
    logic ev, el;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      ev = (k == 4 || k == 5);
      el = (k >= 6 && k <= 12);
      n_checks++;
      if (bus.vga_rvalid !== ev) begin
        n_fail++;
        $display("FAIL lock_vga_rvalid k=%0d got %b want %b", k, bus.vga_rvalid, ev);
      end
      if (ev) begin
        n_checks++;
        if (bus.vga_rdata !== gold[k - 4]) begin
          n_fail++;
          $display("FAIL lock_drain_data k=%0d got %h want %h", k, bus.vga_rdata, gold[k - 4]);
        end
      end
      n_checks++;
      if (bus.lock_ack !== el) begin
        n_fail++;
        $display("FAIL lock_ack k=%0d got %b want %b", k, bus.lock_ack, el);
      end
      if (el) begin
        n_checks++;
        if (bus.vga_rdata !== 8'h00) begin
          n_fail++;
          $display("FAIL lock_vga_blank k=%0d got %h want 00", k, bus.vga_rdata);
        end
      end
      n_checks++;
      if (bus.alg_rvalid !== (k == 11)) begin
        n_fail++;
        $display("FAIL lock_alg_rvalid k=%0d got %b want %b", k, bus.alg_rvalid, k == 11);
      end
      if (k == 11) begin
        n_checks++;
        if (bus.alg_rdata !== gold[9]) begin
          n_fail++;
          $display("FAIL lock_alg_data got %h want %h", bus.alg_rdata, gold[9]);
        end
      end
      drive((k < 2) || (k >= 7 && k <= 9), (k < 2) ? k : 3, k == 7, 0, 9, 8'h00,
            k >= 2 && k < 12);
      #1;
      if (k >= 7 && k <= 9) begin
        n_checks++;
        if (bus.alg_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL lock_gnt k=%0d got %b want 1", k, bus.alg_gnt);
        end
      end
    end
    n_checks++;
    if (bus.underrun_count !== 16'd1) begin
      n_fail++;
      $display("FAIL lock_count got %0d want 1", bus.underrun_count);
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        n_checks++;
        if (bus.mem_wren !== 1'b0) begin
          n_fail++;
          $display("FAIL oor_wren got %b want 0", bus.mem_wren);
        end
      end
      if (k >= 1) begin
        n_checks++;
        if (bus.addr_err !== (k <= 2)) begin
          n_fail++;
          $display("FAIL oor_addr_err k=%0d got %b want %b", k, bus.addr_err, k <= 2);
        end
      end
      if (k >= 2) begin
        n_checks++;
        if (bus.alg_rvalid !== (k == 5)) begin
          n_fail++;
          $display("FAIL oor_rvalid k=%0d got %b want %b", k, bus.alg_rvalid, k == 5);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.alg_rdata !== 8'h00) begin
          n_fail++;
          $display("FAIL oor_rdata got %h want 00", bus.alg_rdata);
        end
      end
      if (k == 0) drive(0, 0, 1, 1, DEPTH, 8'hFF, 0);
      else if (k == 1) drive(0, 0, 1, 0, DEPTH, 8'h00, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        n_checks++;
        if ({bus.vga_rvalid, bus.alg_rvalid} !== 2'b00) begin
          n_fail++;
          $display("FAIL midreset_rvalid k=%0d got %b%b want 00", k, bus.vga_rvalid, bus.alg_rvalid);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (bus.mem_addr !== 18'd0 || bus.underrun_count !== 16'd0 || bus.lock_ack !== 1'b0
            || bus.addr_err !== 1'b0 || bus.mem_wren !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_outputs got addr=%0d cnt=%0d ack=%b err=%b wren=%b want 0",
                   bus.mem_addr, bus.underrun_count, bus.lock_ack, bus.addr_err, bus.mem_wren);
        end
      end
      reset = (k == 1);
      if (k == 0) drive(1, 5, 0, 0, 0, 0, 0);
      else if (k == 1) drive(0, 0, 1, 0, 6, 8'h00, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    int            starve, und, va, p_addr;
    bit            p_req, p_we, vr, forced, egnt, alg_acc, vga_acc, was_req, oor;
    logic [DW-1:0] p_wd, last_vd, last_ad;
    starve = 0; und = 0; p_req = 0; p_we = 0; p_addr = 0; p_wd = '0;
    last_vd = '0; last_ad = '0;
    for (int i = 0; i < N + 8; i++) begin
      e_vv[i] = 0; e_av[i] = 0; e_wren[i] = 0; e_err[i] = 0; e_und[i] = 0;
      e_vd[i] = '0; e_ad[i] = '0;
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N + 6; i++) begin
      @(negedge clock);
      if (e_vv[i]) last_vd = e_vd[i];
      if (e_av[i]) last_ad = e_ad[i];
      if (e_und[i]) und++;
      n_checks++;
      if ({bus.vga_rvalid, bus.alg_rvalid, bus.mem_wren, bus.addr_err, bus.vga_underrun}
          !== {e_vv[i], e_av[i], e_wren[i], e_err[i], e_und[i]}) begin
        n_fail++;
        $display("FAIL rand_flags i=%0d got %b want %b", i,
                 {bus.vga_rvalid, bus.alg_rvalid, bus.mem_wren, bus.addr_err, bus.vga_underrun},
                 {e_vv[i], e_av[i], e_wren[i], e_err[i], e_und[i]});
      end
      n_checks++;
      if (bus.vga_rdata !== last_vd || bus.alg_rdata !== last_ad) begin
        n_fail++;
        $display("FAIL rand_rdata i=%0d got %h %h want %h %h", i,
                 bus.vga_rdata, bus.alg_rdata, last_vd, last_ad);
      end
      n_checks++;
      if (bus.underrun_count !== 16'(und)) begin
        n_fail++;
        $display("FAIL rand_underrun_count i=%0d got %0d want %0d", i, bus.underrun_count, und);
      end
      if (i < N) begin
        vr = ($urandom_range(99) < ((((i / 64) % 2) == 1) ? 93 : 45));
        va = ($urandom_range(19) == 0) ? int'($urandom_range(262143, DEPTH))
                                       : int'($urandom_range(63));
        if (!p_req && $urandom_range(2) != 0) begin
          p_req  = 1;
          p_we   = 1'($urandom_range(1));
          p_addr = ($urandom_range(9) == 0) ? int'($urandom_range(262143, DEPTH))
                                            : int'($urandom_range(63));
          p_wd   = DW'($urandom_range(255));
        end
        drive(vr, va, p_req, p_we, p_addr, p_wd, 0);
        #1;
        forced = (starve == 15);
        egnt   = forced || !vr;
        n_checks++;
        if (bus.alg_gnt !== egnt) begin
          n_fail++;
          $display("FAIL rand_gnt i=%0d got %b want %b", i, bus.alg_gnt, egnt);
        end
        was_req = p_req;
        alg_acc = p_req && egnt;
        vga_acc = vr && !forced;
        e_und[i+1] = vr && forced;
        if (vga_acc) begin
          oor = (va >= DEPTH);
          e_err[i+1] = oor;
          e_vv[i+4]  = 1;
          e_vd[i+4]  = oor ? 8'h00 : gold[va];
        end
        if (alg_acc) begin
          oor = (p_addr >= DEPTH);
          e_err[i+1] = oor;
          if (p_we) begin
            e_wren[i+1] = !oor;
            if (!oor) gold[p_addr] = p_wd;
          end else begin
            e_av[i+4] = 1;
            e_ad[i+4] = oor ? 8'h00 : gold[p_addr];
          end
          p_req = 0;
        end
        starve = (alg_acc || !was_req) ? 0 : starve + 1;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) gold[i] = pattern(i);
    test_reset();
    test_vga_reads();
    test_alg_write_read();
    test_starvation();
    test_lock();
    test_out_of_range();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
